udp_tx_pkt_sched: RTL and testbench
===================================

Name: udp_tx_pkt_sched

Overview:
Upstream feeder for the Ethernet top-level UDP transmit path. It drains 32-bit pixel words from the DDR read-side FIFO and cuts each video frame into fixed-size UDP packets. For each packet it issues the start/byte-count request, serves the UDP core's word requests from the FIFO, and waits for packet completion. It enforces an inter-packet gap and a transmit watchdog, and flags end of frame. It runs entirely in the GMII transmit clock domain (125 MHz).

Parameters:
PKT_WORDS, 256, 32-bit payload words per packet (1024 bytes); legal range 1..16383.
FRAME_PKTS, 600, packets per frame; legal range 1..65535.
IPG_CYCLES, 16, idle clocks after each tx done before the next start; 0 is legal.
TIMEOUT_CYC, 65535, clocks allowed in SEND before the watchdog aborts.
FIFO_CNT_W, 12, width of the FIFO read-level input.

Ports:
i_gmii_clk  in  1  125 MHz GMII tx clock.
i_sys_rstn  in  1  reset, asynchronous, active-low.
i_frame_start  in  1  single-cycle pulse; a new frame is available in the FIFO.
i_fifo_rd_cnt  in  FIFO_CNT_W  words currently readable in the FIFO.
o_fifo_rd_en  out  1  FIFO read strobe; FIFO read latency is 1 clock.
i_fifo_rd_data  in  32  FIFO read data.
o_tx_start_en  out  1  single-cycle packet start pulse to the UDP core.
o_tx_byte_num  out  16  packet payload length in bytes.
o_tx_data  out  32  payload word to the UDP core.
i_fifo_data_req  in  1  UDP core word request; data is expected on the following clock.
i_tx_pkt_done  in  1  UDP core packet-done pulse.
i_tx_busy  in  1  GMII transmit arbiter busy.
o_pkt_idx  out  16  index of the current packet within the frame.
o_frame_done  out  1  single-cycle pulse after the last packet of a frame completes.
o_tx_timeout  out  1  single-cycle pulse when the watchdog aborts a packet.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- States: IDLE, WAIT_DATA, START, SEND, GAP.
- IDLE -> WAIT_DATA on i_frame_start. Action: o_pkt_idx <= 0.
- WAIT_DATA -> START when i_fifo_rd_cnt >= PKT_WORDS and i_tx_busy=0, sampled in the same cycle.
- START lasts exactly 1 cycle:
  - o_tx_start_en=1.
  - o_tx_byte_num = PKT_WORDS*4 (16-bit result); it is held stable from this cycle until the next START.
  - Word counter cleared.
  - Next state SEND.
- SEND:
  - o_fifo_rd_en = i_fifo_data_req, gated by word counter < PKT_WORDS.
  - Each accepted request increments the word counter.
  - o_tx_data = i_fifo_rd_data, registered so it is valid exactly 1 clock after the request.
  - Surplus requests (word counter = PKT_WORDS) do not read the FIFO; o_tx_data holds its last value.
- SEND -> GAP on i_tx_pkt_done. Action: o_pkt_idx increments.
- Watchdog: a cycle counter runs only in SEND. If it reaches TIMEOUT_CYC without i_tx_pkt_done:
  - o_tx_timeout pulses for 1 cycle.
  - State returns to IDLE; the frame is abandoned.
  - The FIFO is not flushed; flushing is the owner's responsibility.
- GAP counts IPG_CYCLES clocks (0 means leave on the next clock). On exit:
  - if o_pkt_idx == FRAME_PKTS: o_frame_done pulses and state goes to IDLE;
  - otherwise state goes to WAIT_DATA.
- i_frame_start outside IDLE is ignored; there is no queuing.
- i_tx_pkt_done outside SEND is ignored.
- A request arriving in the same cycle as i_tx_pkt_done is still served.
- i_tx_busy is checked only in WAIT_DATA.
- Reset asserted mid-packet: outputs return to reset values immediately, because the reset is asynchronous.

Optional Feature:
Macro PKT_HDR_EN.
- When defined, every packet is prefixed with one header word {frame_cnt[15:0], pkt_idx[15:0]}:
  - o_tx_byte_num = PKT_WORDS*4 + 4.
  - The first accepted request in SEND returns the header word without asserting o_fifo_rd_en.
  - The following PKT_WORDS requests read the FIFO.
  - frame_cnt is a 16-bit counter that increments on each accepted i_frame_start and wraps 0xFFFF -> 0.
- When undefined: there is no header, the byte count is PKT_WORDS*4, and frame_cnt logic is absent.

Test Plan:
- Basic packet (PKT_WORDS=4, FRAME_PKTS=2, IPG_CYCLES=3): pulse i_frame_start with rd_cnt=8.
  - Required: start pulse with byte_num=16.
  - 4 requests yield FIFO words 0x0..0x3, each on the clock after its request.
  - Done pulse, then a 3-cycle gap, then a second start.
  - After the second done and gap: o_frame_done=1 for 1 cycle and o_pkt_idx=2.
- Flow hold: rd_cnt=3 with PKT_WORDS=4 -> no start. Raise rd_cnt to 4 while i_tx_busy=1 -> still no start. Drop busy -> start on that cycle.
- Surplus request: 5 requests in one packet -> o_fifo_rd_en asserted exactly 4 times; 5th o_tx_data equals word 3.
- Watchdog (TIMEOUT_CYC=20): no i_tx_pkt_done -> o_tx_timeout pulses 20 cycles after entering SEND; state is IDLE; a new i_frame_start is accepted.
- Frame start ignored: pulse i_frame_start during SEND -> no state or counter change; the frame completes normally.
- PKT_HDR_EN with PKT_WORDS=4: second frame, first packet -> byte_num=20; first word 0x0001_0000, then 4 FIFO words; exactly 4 FIFO reads.

Source files
------------

// File: rtl/udp_tx_pkt_sched.sv
// udp_tx_pkt_sched: cuts FIFO pixel words into fixed-size UDP packets with gap and watchdog.
// Optional PKT_HDR_EN prefixes each packet with a {frame_cnt, pkt_idx} header word.
module udp_tx_pkt_sched #(
  parameter int PKT_WORDS   = 256,
  parameter int FRAME_PKTS  = 600,
  parameter int IPG_CYCLES  = 16,
  parameter int TIMEOUT_CYC = 65535,
  parameter int FIFO_CNT_W  = 12
) (
  input  logic                  i_gmii_clk,
  input  logic                  i_sys_rstn,
  input  logic                  i_frame_start,
  input  logic [FIFO_CNT_W-1:0] i_fifo_rd_cnt,
  output logic                  o_fifo_rd_en,
  input  logic [31:0]           i_fifo_rd_data,
  output logic                  o_tx_start_en,
  output logic [15:0]           o_tx_byte_num,
  output logic [31:0]           o_tx_data,
  input  logic                  i_fifo_data_req,
  input  logic                  i_tx_pkt_done,
  input  logic                  i_tx_busy,
  output logic [15:0]           o_pkt_idx,
  output logic                  o_frame_done,
  output logic                  o_tx_timeout
);
`ifdef PKT_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int LIM = PKT_WORDS + HDR;
  typedef enum logic [2:0] {IDLE, WAIT_DATA, START, SEND, GAP} state_t;
  state_t state;
  logic [14:0] wc;
  logic [31:0] wd, gc, data_hold;
  logic rd_dly, take;
  assign take = state == SEND && i_fifo_data_req && 32'(wc) < LIM;
`ifdef PKT_HDR_EN
  logic [15:0] frame_cnt, frame_id;
  assign o_fifo_rd_en = take && wc != 15'd0;
  always_ff @(posedge i_gmii_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      frame_cnt <= 16'd0;
      frame_id  <= 16'd0;
    end else if (state == IDLE && i_frame_start) begin
      frame_id  <= frame_cnt;
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign o_fifo_rd_en = take;
`endif
  // FIFO data arrives one clock after the read strobe; pass it straight through that clock, hold afterwards
  assign o_tx_data = rd_dly ? i_fifo_rd_data : data_hold;
  always_ff @(posedge i_gmii_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      rd_dly    <= 1'b0;
      data_hold <= 32'd0;
    end else begin
      rd_dly <= o_fifo_rd_en;
      if (rd_dly) data_hold <= i_fifo_rd_data;
`ifdef PKT_HDR_EN
      else if (take && wc == 15'd0) data_hold <= {frame_id, o_pkt_idx};
`endif
    end
  end
  always_ff @(posedge i_gmii_clk or negedge i_sys_rstn) begin
    if (!i_sys_rstn) begin
      state         <= IDLE;
      o_tx_start_en <= 1'b0;
      o_tx_byte_num <= 16'd0;
      o_pkt_idx     <= 16'd0;
      o_frame_done  <= 1'b0;
      o_tx_timeout  <= 1'b0;
      wc            <= 15'd0;
      wd            <= 32'd0;
      gc            <= 32'd0;
    end else begin
      o_tx_start_en <= 1'b0;
      o_frame_done  <= 1'b0;
      o_tx_timeout  <= 1'b0;
      if (take) wc <= wc + 15'd1;
      case (state)
        IDLE: if (i_frame_start) begin
          state     <= WAIT_DATA;
          o_pkt_idx <= 16'd0;
        end
        WAIT_DATA: if (32'(i_fifo_rd_cnt) >= PKT_WORDS && !i_tx_busy) begin
          state         <= START;
          o_tx_start_en <= 1'b1;
          o_tx_byte_num <= 16'(LIM * 4);
        end
        START: begin
          state <= SEND;
          wc    <= 15'd0;
          wd    <= 32'd0;
        end
        SEND: begin
          wd <= wd + 32'd1;
          if (i_tx_pkt_done) begin
            state     <= GAP;
            o_pkt_idx <= o_pkt_idx + 16'd1;
            gc        <= 32'd0;
          end else if (wd + 32'd1 >= TIMEOUT_CYC) begin
            state        <= IDLE;
            o_tx_timeout <= 1'b1;
          end
        end
        GAP: begin
          gc <= gc + 32'd1;
          if (gc + 32'd1 >= IPG_CYCLES) begin
            state        <= o_pkt_idx == 16'(FRAME_PKTS) ? IDLE : WAIT_DATA;
            o_frame_done <= o_pkt_idx == 16'(FRAME_PKTS);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_pkt_sched.sv
// tb_udp_tx_pkt_sched: directed checks of packetising, gap, flow hold, watchdog and async reset.
module tb_udp_tx_pkt_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic frame_start = 1'b0, req = 1'b0, done = 1'b0, busy = 1'b0;
  logic [11:0] rd_cnt = 12'd0;
  logic [31:0] rd_data = 32'd0, ptr = 32'd0, tx_data;
  logic rd_en, start_en, frame_done, timeout;
  logic [15:0] byte_num, pkt_idx;
  int vectors = 0, errs = 0, nrd = 0, nto = 0, n0;

  udp_tx_pkt_sched #(.PKT_WORDS(4), .FRAME_PKTS(2), .IPG_CYCLES(3), .TIMEOUT_CYC(20), .FIFO_CNT_W(12)) dut (
    .i_gmii_clk(clk), .i_sys_rstn(rst_n), .i_frame_start(frame_start), .i_fifo_rd_cnt(rd_cnt),
    .o_fifo_rd_en(rd_en), .i_fifo_rd_data(rd_data), .o_tx_start_en(start_en), .o_tx_byte_num(byte_num),
    .o_tx_data(tx_data), .i_fifo_data_req(req), .i_tx_pkt_done(done), .i_tx_busy(busy),
    .o_pkt_idx(pkt_idx), .o_frame_done(frame_done), .o_tx_timeout(timeout));

  always #5 clk = ~clk;

  // FIFO with one clock read latency; word k holds value k
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 32'd0;
      rd_data <= 32'd0;
    end else if (rd_en) begin
      rd_data <= ptr;
      ptr <= ptr + 32'd1;
    end
  end

  always @(posedge clk) begin
    if (rd_en) nrd <= nrd + 1;
    if (timeout) nto <= nto + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (2) step;
    chk("rst start_en", 32'(start_en), 0);
    chk("rst byte_num", 32'(byte_num), 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst pkt_idx", 32'(pkt_idx), 0);
    chk("rst frame_done", 32'(frame_done), 0);
    chk("rst timeout", 32'(timeout), 0);
    chk("rst rd_en", 32'(rd_en), 0);
    rst_n = 1'b1;
    step;
`ifndef PKT_HDR_EN
    rd_cnt = 12'd8;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    chk("wait start_en", 32'(start_en), 0);
    step;
    chk("pkt0 start_en", 32'(start_en), 1);
    chk("pkt0 byte_num", 32'(byte_num), 16);
    step;
    chk("send start_en low", 32'(start_en), 0);
    n0 = nrd;
    for (int i = 0; i < 5; i++) begin
      req = 1'b1;
      frame_start = (i == 2);
      #1;
      chk($sformatf("pkt0 rd_en %0d", i), 32'(rd_en), 32'(i < 4));
      step;
      chk($sformatf("pkt0 tx_data %0d", i), tx_data, i < 4 ? 32'(i) : 32'd3);
    end
    req = 1'b0;
    frame_start = 1'b0;
    chk("pkt0 reads", 32'(nrd - n0), 4);
    done = 1'b1;
    step;
    done = 1'b0;
    chk("pkt0 idx", 32'(pkt_idx), 1);
    for (int k = 1; k <= 3; k++) begin
      step;
      chk($sformatf("gap %0d start_en", k), 32'(start_en), 0);
    end
    step;
    chk("pkt1 start_en", 32'(start_en), 1);
    step;
    for (int i = 0; i < 4; i++) begin
      req = 1'b1;
      step;
      chk($sformatf("pkt1 tx_data %0d", i), tx_data, 32'(4 + i));
    end
    req = 1'b0;
    done = 1'b1;
    step;
    done = 1'b0;
    chk("pkt1 idx", 32'(pkt_idx), 2);
    step;
    step;
    chk("frame_done early", 32'(frame_done), 0);
    step;
    chk("frame_done", 32'(frame_done), 1);
    chk("frame pkt_idx", 32'(pkt_idx), 2);
    step;
    chk("frame_done pulse", 32'(frame_done), 0);
    chk("idle no start", 32'(start_en), 0);
    chk("no timeout yet", 32'(nto), 0);
    rd_cnt = 12'd3;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    repeat (3) begin
      step;
      chk("hold low cnt", 32'(start_en), 0);
    end
    rd_cnt = 12'd4;
    busy = 1'b1;
    repeat (2) begin
      step;
      chk("hold busy", 32'(start_en), 0);
    end
    busy = 1'b0;
    step;
    chk("hold release start", 32'(start_en), 1);
    chk("new frame idx", 32'(pkt_idx), 0);
    step;
    for (int k = 1; k < 20; k++) begin
      step;
      if (k == 19) chk("wd before", 32'(timeout), 0);
    end
    step;
    chk("wd timeout", 32'(timeout), 1);
    chk("wd byte_num held", 32'(byte_num), 16);
    step;
    chk("wd pulse", 32'(timeout), 0);
    chk("wd idle", 32'(start_en), 0);
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    step;
    chk("post wd start", 32'(start_en), 1);
    step;
    req = 1'b1;
    step;
    req = 1'b0;
    chk("post wd data", tx_data, 8);
    rst_n = 1'b0;
    #1;
    chk("async rst tx_data", tx_data, 0);
    chk("async rst byte_num", 32'(byte_num), 0);
    chk("async rst rd_en", 32'(rd_en), 0);
    step;
    rst_n = 1'b1;
    step;
    chk("timeouts total", 32'(nto), 1);
`else
    rd_cnt = 12'd8;
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    step;
    chk("hdr f0 start_en", 32'(start_en), 1);
    step;
    repeat (20) step;
    chk("hdr f0 timeout", 32'(timeout), 1);
    frame_start = 1'b1;
    step;
    frame_start = 1'b0;
    step;
    chk("hdr start_en", 32'(start_en), 1);
    chk("hdr byte_num", 32'(byte_num), 20);
    step;
    n0 = nrd;
    for (int i = 0; i < 5; i++) begin
      req = 1'b1;
      #1;
      chk($sformatf("hdr rd_en %0d", i), 32'(rd_en), 32'(i > 0));
      step;
      chk($sformatf("hdr tx_data %0d", i), tx_data, i == 0 ? 32'h0001_0000 : 32'(i - 1));
    end
    req = 1'b0;
    chk("hdr reads", 32'(nrd - n0), 4);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
